// File: rtl/exe_arbiter_if.sv
// Handshake bundle between the two requesters, the shared EXE stage and the
// result consumer. The arbiter connects through the slave modport.
interface exe_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_value1;
    logic [WIDTH-1:0] req0_value2;
    logic [WIDTH-1:0] req0_immediate;
    logic [2:0]       req0_alu_oc;
    logic             req0_ir_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_value1;
    logic [WIDTH-1:0] req1_value2;
    logic [WIDTH-1:0] req1_immediate;
    logic [2:0]       req1_alu_oc;
    logic             req1_ir_op;

    logic [WIDTH-1:0] exe_value1;
    logic [WIDTH-1:0] exe_value2;
    logic [WIDTH-1:0] exe_immediate;
    logic [2:0]       exe_alu_oc;
    logic             exe_ir_op;
    logic [WIDTH-1:0] exe_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;

    modport master (
        output req0_valid, req0_value1, req0_value2, req0_immediate, req0_alu_oc, req0_ir_op,
        input  req0_ready,
        output req1_valid, req1_value1, req1_value2, req1_immediate, req1_alu_oc, req1_ir_op,
        input  req1_ready,
        input  exe_value1, exe_value2, exe_immediate, exe_alu_oc, exe_ir_op,
        output exe_result,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_value1, req0_value2, req0_immediate, req0_alu_oc, req0_ir_op,
        output req0_ready,
        input  req1_valid, req1_value1, req1_value2, req1_immediate, req1_alu_oc, req1_ir_op,
        output req1_ready,
        output exe_value1, exe_value2, exe_immediate, exe_alu_oc, exe_ir_op,
        input  exe_result,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready
    );
endinterface

// File: rtl/exe_arbiter.sv
// Round-robin arbiter sharing the EXE stage between ID (port 0) and a
// secondary requester (port 1); one operation in flight at a time.
//
// state | meaning
// IDLE  | ready to grant one valid requester
// WAIT  | EXE inputs held, counting down the EXE latency
// RESP  | result held on rsp_* until the consumer takes it
module exe_arbiter #(
    parameter int WIDTH   = 32,
    parameter int EXE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    exe_arbiter_if.slave   bus,
    output logic           busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             last_grant;

    logic             any_valid;
    logic             gnt_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_value1;
    logic [WIDTH-1:0] sel_value2;
    logic [WIDTH-1:0] sel_immediate;
    logic [2:0]       sel_alu_oc;
    logic             sel_ir_op;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        any_valid     = bus.req0_valid | bus.req1_valid;
        gnt_idx       = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept        = (state == IDLE) & any_valid;
        sel_value1    = gnt_idx ? bus.req1_value1    : bus.req0_value1;
        sel_value2    = gnt_idx ? bus.req1_value2    : bus.req0_value2;
        sel_immediate = gnt_idx ? bus.req1_immediate : bus.req0_immediate;
        sel_alu_oc    = gnt_idx ? bus.req1_alu_oc    : bus.req0_alu_oc;
        sel_ir_op     = gnt_idx ? bus.req1_ir_op     : bus.req0_ir_op;
    end

    assign bus.req0_ready = accept & ~gnt_idx;
    assign bus.req1_ready = accept &  gnt_idx;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            last_grant        <= 1'b1;
            bus.exe_value1    <= '0;
            bus.exe_value2    <= '0;
            bus.exe_immediate <= '0;
            bus.exe_alu_oc    <= '0;
            bus.exe_ir_op     <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= 1'b0;
            bus.rsp_result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.exe_value1    <= sel_value1;
                        bus.exe_value2    <= sel_value2;
                        bus.exe_immediate <= sel_immediate;
                        bus.exe_alu_oc    <= sel_alu_oc;
                        bus.exe_ir_op     <= sel_ir_op;
                        bus.rsp_id        <= gnt_idx;
                        last_grant        <= gnt_idx;
                        cnt               <= 4'(EXE_LAT);
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rsp_result <= bus.exe_result;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_arbiter.sv
// Bench for exe_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level reference model.
module tb_exe_arbiter;
    localparam int WIDTH = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy_a, busy_b;
    int   errors = 0;
    int   checks = 0;

    exe_arbiter_if #(.WIDTH(WIDTH)) bus_a ();
    exe_arbiter_if #(.WIDTH(WIDTH)) bus_b ();

    exe_arbiter #(.WIDTH(WIDTH), .EXE_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a));
    exe_arbiter #(.WIDTH(WIDTH), .EXE_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b));

    always #5 clk = ~clk;

    // EXE model: op2 registered on clk, result = value1 + op2
    logic [WIDTH-1:0] op2_a, op2_b;
    always_ff @(posedge clk) op2_a <= bus_a.exe_ir_op ? bus_a.exe_value2 : bus_a.exe_immediate;
    always_ff @(posedge clk) op2_b <= bus_b.exe_ir_op ? bus_b.exe_value2 : bus_b.exe_immediate;
    assign bus_a.exe_result = bus_a.exe_value1 + op2_a;
    assign bus_b.exe_result = bus_b.exe_value1 + op2_b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.req0_valid = 0; bus_a.req0_value1 = 0; bus_a.req0_value2 = 0;
        bus_a.req0_immediate = 0; bus_a.req0_alu_oc = 0; bus_a.req0_ir_op = 0;
        bus_a.req1_valid = 0; bus_a.req1_value1 = 0; bus_a.req1_value2 = 0;
        bus_a.req1_immediate = 0; bus_a.req1_alu_oc = 0; bus_a.req1_ir_op = 0;
        bus_a.rsp_ready = 0;
        bus_b.req0_valid = 0; bus_b.req0_value1 = 0; bus_b.req0_value2 = 0;
        bus_b.req0_immediate = 0; bus_b.req0_alu_oc = 0; bus_b.req0_ir_op = 0;
        bus_b.req1_valid = 0; bus_b.req1_value1 = 0; bus_b.req1_value2 = 0;
        bus_b.req1_immediate = 0; bus_b.req1_alu_oc = 0; bus_b.req1_ir_op = 0;
        bus_b.rsp_ready = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},       busy_a, 0);
        check({tag, " rsp_valid"},  bus_a.rsp_valid, 0);
        check({tag, " rsp_id"},     bus_a.rsp_id, 0);
        check({tag, " rsp_result"}, bus_a.rsp_result, 0);
        check({tag, " exe_value1"}, bus_a.exe_value1, 0);
        check({tag, " exe_value2"}, bus_a.exe_value2, 0);
        check({tag, " exe_imm"},    bus_a.exe_immediate, 0);
        check({tag, " exe_alu_oc"}, bus_a.exe_alu_oc, 0);
        check({tag, " exe_ir_op"},  bus_a.exe_ir_op, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        #1;
        check_zero_outputs("reset");
        check("reset req0_ready", bus_a.req0_ready, 0);
        check("reset busy_b", busy_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drive_a(input bit port, input bit vld, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] imm,
                           input logic [2:0] oc, input bit ir);
        if (!port) begin
            bus_a.req0_valid = vld; bus_a.req0_value1 = v1; bus_a.req0_value2 = v2;
            bus_a.req0_immediate = imm; bus_a.req0_alu_oc = oc; bus_a.req0_ir_op = ir;
        end else begin
            bus_a.req1_valid = vld; bus_a.req1_value1 = v1; bus_a.req1_value2 = v2;
            bus_a.req1_immediate = imm; bus_a.req1_alu_oc = oc; bus_a.req1_ir_op = ir;
        end
    endtask

    // Waits (bounded) for rsp_valid on bus_a; returns edges counted
    task automatic wait_rsp_a(output int n);
        n = 0;
        while (!bus_a.rsp_valid && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [2:0]  oc;
        bit          ir;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, nresp, cyc;
        bit grants[$];
        bit rids[$];
        logic [31:0] rres[$];
        logic [31:0] held_res;

        rst_n = 0;
        idle_inputs();

        vecs[0] = '{1'b0, 32'd5,          32'd7,          32'd0,      3'd0, 1'b1, 32'd12};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd0,          32'h100,    3'd1, 1'b0, 32'h0000_00FF};
        vecs[2] = '{1'b1, 32'h10,         32'hFFFF,       32'h20,     3'd2, 1'b0, 32'h30};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  32'd1,      3'd3, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'd0,          32'd1,          32'hDEAD,   3'd7, 1'b0, 32'hDEAD};

        do_reset();

        // Directed single operations, consumer always ready
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_a(vecs[i].port, 1, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].oc, vecs[i].ir);
            bus_a.rsp_ready = 1;
            #1;
            check($sformatf("v%0d ready", i), vecs[i].port ? bus_a.req1_ready : bus_a.req0_ready, 1);
            check($sformatf("v%0d other ready", i), vecs[i].port ? bus_a.req0_ready : bus_a.req1_ready, 0);
            @(posedge clk);
            @(negedge clk);
            drive_a(vecs[i].port, 0, 0, 0, 0, 0, 0);
            check($sformatf("v%0d busy", i), busy_a, 1);
            check($sformatf("v%0d exe_value1", i), bus_a.exe_value1, vecs[i].v1);
            check($sformatf("v%0d exe_alu_oc", i), bus_a.exe_alu_oc, vecs[i].oc);
            check($sformatf("v%0d exe_ir_op", i), bus_a.exe_ir_op, vecs[i].ir);
            wait_rsp_a(n);
            check($sformatf("v%0d latency", i), n, LAT_A + 1);
            check($sformatf("v%0d rsp_result", i), bus_a.rsp_result, vecs[i].exp);
            check($sformatf("v%0d rsp_id", i), bus_a.rsp_id, vecs[i].port);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d rsp_valid drop", i), bus_a.rsp_valid, 0);
            check($sformatf("v%0d busy drop", i), busy_a, 0);
        end

        // Both requesters held valid: alternating grants starting at port 0
        do_reset();
        @(negedge clk);
        drive_a(0, 1, 32'd1, 32'd2, 32'd0, 3'd0, 1'b1);
        drive_a(1, 1, 32'd10, 32'd0, 32'd20, 3'd5, 1'b0);
        bus_a.rsp_ready = 1;
        nresp = 0;
        cyc = 0;
        while (nresp < 4 && cyc < 60) begin
            #1;
            if (bus_a.req0_ready) grants.push_back(1'b0);
            if (bus_a.req1_ready) grants.push_back(1'b1);
            if (bus_a.rsp_valid) begin
                rids.push_back(bus_a.rsp_id);
                rres.push_back(bus_a.rsp_result);
                nresp++;
            end
            @(negedge clk);
            cyc++;
        end
        drive_a(0, 0, 0, 0, 0, 0, 0);
        drive_a(1, 0, 0, 0, 0, 0, 0);
        check("rr responses", nresp, 4);
        check("rr grant count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check($sformatf("rr grant %0d", i), grants[i], i % 2);
            if (i < rids.size()) begin
                check($sformatf("rr rsp_id %0d", i), rids[i], i % 2);
                check($sformatf("rr rsp_result %0d", i), rres[i], (i % 2) ? 32'd30 : 32'd3);
            end
        end

        // Consumer stalls in RESP while requester 1 waits
        @(negedge clk);
        drive_a(0, 1, 32'h1234, 32'h1111, 32'd0, 3'd2, 1'b1);
        bus_a.rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        wait_rsp_a(n);
        check("stall latency", n, LAT_A + 1);
        drive_a(1, 1, 32'h50, 32'd0, 32'h5, 3'd1, 1'b0);
        held_res = 32'h2345;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall rsp_valid %0d", k), bus_a.rsp_valid, 1);
            check($sformatf("stall rsp_result %0d", k), bus_a.rsp_result, held_res);
            check($sformatf("stall rsp_id %0d", k), bus_a.rsp_id, 0);
            check($sformatf("stall req1_ready %0d", k), bus_a.req1_ready, 0);
            @(negedge clk);
        end
        bus_a.rsp_ready = 1;
        #1;
        check("stall release req1_ready", bus_a.req1_ready, 0);
        @(negedge clk);
        #1;
        check("stall resume req1_ready", bus_a.req1_ready, 1);
        check("stall resume busy", busy_a, 0);
        @(posedge clk);
        @(negedge clk);
        drive_a(1, 0, 0, 0, 0, 0, 0);
        wait_rsp_a(n);
        check("stall second id", bus_a.rsp_id, 1);
        check("stall second result", bus_a.rsp_result, 32'h55);
        @(negedge clk);

        // Reset in the middle of WAIT
        drive_a(0, 1, 32'hAAAA, 32'h5, 32'd0, 3'd7, 1'b1);
        bus_a.rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        check("midreset busy before", busy_a, 1);
        rst_n = 0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1;
        drive_a(0, 1, 32'd3, 32'd4, 32'd0, 3'd0, 1'b1);
        drive_a(1, 1, 32'd9, 32'd0, 32'd1, 3'd0, 1'b0);
        #1;
        check("post reset req0_ready", bus_a.req0_ready, 1);
        check("post reset req1_ready", bus_a.req1_ready, 0);
        check("post reset rsp_valid", bus_a.rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        drive_a(1, 0, 0, 0, 0, 0, 0);
        check("post reset no stale rsp", bus_a.rsp_valid, 0);
        wait_rsp_a(n);
        check("post reset latency", n, LAT_A + 1);
        check("post reset id", bus_a.rsp_id, 0);
        check("post reset result", bus_a.rsp_result, 32'd7);
        @(negedge clk);

        // Longer EXE latency on the second instance
        bus_b.req1_valid = 1; bus_b.req1_value1 = 32'd100; bus_b.req1_value2 = 32'hFFFF;
        bus_b.req1_immediate = 32'd23; bus_b.req1_alu_oc = 3'd4; bus_b.req1_ir_op = 1'b0;
        bus_b.rsp_ready = 1;
        #1;
        check("lat3 req1_ready", bus_b.req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_b.req1_valid = 0;
        n = 0;
        while (!bus_b.rsp_valid && n < 30) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("lat3 latency", n, LAT_B + 1);
        check("lat3 result", bus_b.rsp_result, 32'd123);
        check("lat3 id", bus_b.rsp_id, 1);
        @(negedge clk);
        check("lat3 rsp_valid drop", bus_b.rsp_valid, 0);

        // Randomized traffic against a transaction-level model
        do_reset();
        begin
            bit m_busy = 0, m_rv = 0, m_last = 1, m_id = 0;
            int m_wait = 0;
            logic [31:0] m_res = 0, m_v1 = 0, m_v2 = 0, m_imm = 0;
            logic [2:0] m_oc = 0;
            bit m_ir = 0;
            bit acc0 = 0, acc1 = 0;
            bit v0, v1, g_any, g;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (acc0 || !bus_a.req0_valid)
                    drive_a(0, $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom,
                            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                if (acc1 || !bus_a.req1_valid)
                    drive_a(1, $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom,
                            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                bus_a.rsp_ready = 1'($urandom_range(0, 1));
                #1;
                v0 = bus_a.req0_valid;
                v1 = bus_a.req1_valid;
                g_any = !m_busy && (v0 || v1);
                g = (v0 && v1) ? !m_last : v1;
                check("rand req0_ready", bus_a.req0_ready, g_any && !g);
                check("rand req1_ready", bus_a.req1_ready, g_any && g);
                check("rand busy", busy_a, m_busy);
                check("rand rsp_valid", bus_a.rsp_valid, m_rv);
                if (m_rv) begin
                    check("rand rsp_id", bus_a.rsp_id, m_id);
                    check("rand rsp_result", bus_a.rsp_result, m_res);
                end
                if (m_busy) begin
                    check("rand exe_value1", bus_a.exe_value1, m_v1);
                    check("rand exe_value2", bus_a.exe_value2, m_v2);
                    check("rand exe_imm", bus_a.exe_immediate, m_imm);
                    check("rand exe_alu_oc", bus_a.exe_alu_oc, m_oc);
                    check("rand exe_ir_op", bus_a.exe_ir_op, m_ir);
                end
                acc0 = 0;
                acc1 = 0;
                if (g_any) begin
                    m_busy = 1;
                    m_id   = g;
                    m_last = g;
                    m_v1   = g ? bus_a.req1_value1    : bus_a.req0_value1;
                    m_v2   = g ? bus_a.req1_value2    : bus_a.req0_value2;
                    m_imm  = g ? bus_a.req1_immediate : bus_a.req0_immediate;
                    m_oc   = g ? bus_a.req1_alu_oc    : bus_a.req0_alu_oc;
                    m_ir   = g ? bus_a.req1_ir_op     : bus_a.req0_ir_op;
                    m_res  = m_v1 + (m_ir ? m_v2 : m_imm);
                    m_wait = LAT_A + 1;
                    if (g) acc1 = 1; else acc0 = 1;
                end else if (m_busy && !m_rv) begin
                    m_wait--;
                    if (m_wait == 0) m_rv = 1;
                end else if (m_rv && bus_a.rsp_ready) begin
                    m_rv   = 0;
                    m_busy = 0;
                end
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
